prism_state_engine: RTL and testbench
=====================================

# prism_state_engine

Programmable finite-state engine that consumes the PRISM configuration bus held in the latch array and executes it as a state-transition table. Each of the DEPTH 64-bit configuration words describes one state: a condition built from the synchronized input pins and a per-state dwell counter, the next states for true and false, and the PMOD output values for each case. The block sits directly downstream of the configuration latch array inside the PRISM peripheral. It drives the output PMOD and the peripheral interrupt.

## Interface
- WIDTH, 64, bits per state word (fixed format below; must be 64)
- DEPTH, 8, number of states; state index width SW = 3
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  run enable; low forces idle state
- cfg_bus  in  WIDTH*DEPTH  state words; state i = cfg_bus[(i+1)*WIDTH-1 -: WIDTH]
- cfg_busy  in  1  config loader active; engine freezes
- pins  in  8  synchronized ui_in
- irq_clr  in  1  one-cycle pulse; clears irq
- pins_out  out  8  registered output value
- state  out  SW  current state index
- count  out  16  dwell counter of current state
- irq  out  1  sticky interrupt flag

## Operation
- State word fields: [2:0] next_true; [5:3] next_false; [8:6] sel_a; [9] inv_a; [12:10] sel_b; [13] inv_b; [15:14] op; [23:16] out_true; [31:24] out_false; [47:32] cmp; [48] cnt_en; [49] irq_en; [63:50] reserved, ignored.
- a = pins[sel_a] ^ inv_a; b = pins[sel_b] ^ inv_b.
- op: 00 → a; 01 → a & b; 10 → a | b; 11 → constant 1.
- cond = cnt_en ? (logic & (count == cmp)) : logic.
- Each active cycle:
  - state ← cond ? next_true : next_false.
  - pins_out ← cond ? out_true : out_false.
- Counter:
  - Clears to 0 when the next state differs from the current state.
  - Otherwise increments, saturating at 16'hFFFF.
  - A self-loop (next == current) keeps counting.
- irq:
  - Set when irq_en & cond in an active cycle.
  - Cleared by irq_clr.
  - Set wins over a simultaneous clear.
- Modes:
  - Active = enable & !cfg_busy.
  - Frozen (enable & cfg_busy): state, count, pins_out and irq-set are held; irq_clr still works.
  - Idle (!enable): state = 0, count = 0, pins_out = 0; irq is held.
- cfg_bus is treated as static while active. Changes while frozen take effect on the first active cycle.

## Timing
- Reset values: state = 0, count = 0, pins_out = 8'h00, irq = 0.
- One-cycle latency:
  - pins sampled at edge N determine state, pins_out and irq after edge N+1.
  - pins itself already carries 2 cycles of synchronizer delay upstream.
- count reads 0 during the first cycle in a new state, and n after n cycles of dwell in that state.
- With cnt_en and op = 11, the state exits exactly cmp+1 cycles after entry.
- cmp = 0 with cnt_en exits after 1 cycle.
- A saturated counter never matches cmp < FFFF again.
- Reset mid-run: all outputs return to reset values on the next edge. Enable deassert mid-run: same, except irq is held.
- When a freeze ends, execution resumes from the held state and count with no extra cycle.

## Structure
- Package prism_pkg holds:
  - field offset and width localparams;
  - op encodings OP_A, OP_AND, OP_OR, OP_ONE;
  - SW and counter width CW = 16.
- Sub-module prism_cond_eval (combinational) computes cond from the state word, pins and count.
- The top module contains the word mux, state/counter/output registers and irq logic.

## Test plan
- Reset, then enable with all words zero → state stays 0, pins_out = 8'h00 (op 00, sel_a 0, pins = 0 → false path).
- State 0 has op = 01, sel_a = 2, sel_b = 5, next_true = 3, out_true = 8'hA5. Drive pins = 8'b0010_0100 → one cycle later state = 3, pins_out = 8'hA5. Drive pins = 8'h04 instead → false path.
- State 1 has cnt_en, op = 11, cmp = 4, next_true = 2, next_false = 1 → state 1 for 5 cycles, count 0..4, state 2 on the 6th edge, count 0.
- irq_en on a true transition → irq = 1 and stays set. irq_clr pulsed in the same cycle as a new set → irq remains 1. Clear alone → 0.
- cfg_busy raised mid-dwell for 10 cycles → state, count and pins_out are held. After release, counting resumes from the held value.
- enable dropped while in state 5 with irq = 1 → state 0, count 0, pins_out 0, irq 1. rst_n low → irq 0.

Source files
------------

// File: rtl/prism_pkg.sv
// prism_pkg
// Shared definitions for the PRISM state engine: state-word field layout,
// condition operator encodings, engine dimensions and the run-mode type.
package prism_pkg;

  localparam int WIDTH = 64;  // bits per state word
  localparam int DEPTH = 8;   // number of states
  localparam int SW    = 3;   // state index width
  localparam int CW    = 16;  // dwell counter width

  // State word field offsets / widths
  localparam int F_NT_LSB    = 0;   // next_true
  localparam int F_NF_LSB    = 3;   // next_false
  localparam int F_SELA_LSB  = 6;
  localparam int F_INVA_BIT  = 9;
  localparam int F_SELB_LSB  = 10;
  localparam int F_INVB_BIT  = 13;
  localparam int F_OP_LSB    = 14;
  localparam int F_OP_W      = 2;
  localparam int F_OUTT_LSB  = 16;
  localparam int F_OUTF_LSB  = 24;
  localparam int F_OUT_W     = 8;
  localparam int F_CMP_LSB   = 32;
  localparam int F_CNTEN_BIT = 48;
  localparam int F_IRQEN_BIT = 49;
  localparam int F_RSVD_LSB  = 50;

  localparam logic [F_OP_W-1:0] OP_A   = 2'b00;
  localparam logic [F_OP_W-1:0] OP_AND = 2'b01;
  localparam logic [F_OP_W-1:0] OP_OR  = 2'b10;
  localparam logic [F_OP_W-1:0] OP_ONE = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_FROZEN = 2'd1,
    MODE_ACTIVE = 2'd2
  } mode_e;

  function automatic mode_e decode_mode(input logic enable, input logic cfg_busy);
    if (!enable)  return MODE_IDLE;
    if (cfg_busy) return MODE_FROZEN;
    return MODE_ACTIVE;
  endfunction

endpackage

// File: rtl/prism_cond_eval.sv
// prism_cond_eval
// Combinational condition evaluator for the current state word.
// Ports:
//   i_pins   [7:0]  synchronized input pins
//   i_sel_a  [2:0]  pin index for operand a, i_inv_a inverts it
//   i_sel_b  [2:0]  pin index for operand b, i_inv_b inverts it
//   i_op     [1:0]  combine operator (a, a&b, a|b, 1)
//   i_cnt_en        qualify with dwell counter match
//   i_cmp    [15:0] dwell compare value
//   i_count  [15:0] current dwell count
//   o_cond          evaluated condition
module prism_cond_eval
  import prism_pkg::*;
(
  input  logic [7:0]        i_pins,
  input  logic [2:0]        i_sel_a,
  input  logic              i_inv_a,
  input  logic [2:0]        i_sel_b,
  input  logic              i_inv_b,
  input  logic [F_OP_W-1:0] i_op,
  input  logic              i_cnt_en,
  input  logic [CW-1:0]     i_cmp,
  input  logic [CW-1:0]     i_count,
  output logic              o_cond
);

  logic w_a;
  logic w_b;
  logic w_logic;

  assign w_a = i_pins[i_sel_a] ^ i_inv_a;
  assign w_b = i_pins[i_sel_b] ^ i_inv_b;

  always_comb begin
    w_logic = 1'b0;
    case (i_op)
      OP_A:    w_logic = w_a;
      OP_AND:  w_logic = w_a & w_b;
      OP_OR:   w_logic = w_a | w_b;
      OP_ONE:  w_logic = 1'b1;
      default: w_logic = 1'b0;
    endcase
  end

  assign o_cond = i_cnt_en ? (w_logic & (i_count == i_cmp)) : w_logic;

endmodule

// File: rtl/prism_state_engine.sv
// prism_state_engine
// Executes the PRISM configuration words as a state-transition table.
// The current state selects its word from the config bus; the word's
// condition picks next state and output value each active cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_enable              run enable, low forces idle (irq held)
//   i_cfg_bus [511:0]     DEPTH x 64-bit state words, state i at [(i+1)*64-1 -: 64]
//   i_cfg_busy            loader active: engine state frozen
//   i_pins    [7:0]       synchronized input pins
//   i_irq_clr             clears the sticky irq
//   o_pins_out [7:0]      registered output value
//   o_state   [2:0]       current state index
//   o_count   [15:0]      dwell counter of current state
//   o_irq                 sticky interrupt
module prism_state_engine
  import prism_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  input  logic [WIDTH*DEPTH-1:0] i_cfg_bus,
  input  logic                   i_cfg_busy,
  input  logic [7:0]             i_pins,
  input  logic                   i_irq_clr,
  output logic [7:0]             o_pins_out,
  output logic [SW-1:0]          o_state,
  output logic [CW-1:0]          o_count,
  output logic                   o_irq
);

  logic [SW-1:0]    r_state;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_pins_out;
  logic             r_irq;

  logic [WIDTH-1:0] w_word;
  logic             w_cond;
  logic [SW-1:0]    w_next;
  logic             w_irq_set;
  mode_e            w_mode;
  logic             w_unused_rsvd;

  // word select: state index times 64
  assign w_word = i_cfg_bus[{r_state, 6'd0} +: WIDTH];

  // reserved bits carry no meaning; folded here only to keep them referenced
  assign w_unused_rsvd = ^w_word[WIDTH-1:F_RSVD_LSB];

  prism_cond_eval u_cond_eval (
    .i_pins   (i_pins),
    .i_sel_a  (w_word[F_SELA_LSB +: 3]),
    .i_inv_a  (w_word[F_INVA_BIT]),
    .i_sel_b  (w_word[F_SELB_LSB +: 3]),
    .i_inv_b  (w_word[F_INVB_BIT]),
    .i_op     (w_word[F_OP_LSB +: F_OP_W]),
    .i_cnt_en (w_word[F_CNTEN_BIT]),
    .i_cmp    (w_word[F_CMP_LSB +: CW]),
    .i_count  (r_count),
    .o_cond   (w_cond)
  );

  assign w_mode    = decode_mode(i_enable, i_cfg_busy);
  assign w_next    = w_cond ? w_word[F_NT_LSB +: SW] : w_word[F_NF_LSB +: SW];
  assign w_irq_set = (w_mode == MODE_ACTIVE) & w_word[F_IRQEN_BIT] & w_cond;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= '0;
      r_count    <= '0;
      r_pins_out <= '0;
      r_irq      <= 1'b0;
    end else begin
      // set has priority over a coincident clear
      if (w_irq_set)
        r_irq <= 1'b1;
      else if (i_irq_clr)
        r_irq <= 1'b0;

      case (w_mode)
        MODE_IDLE: begin
          r_state    <= '0;
          r_count    <= '0;
          r_pins_out <= '0;
        end
        MODE_ACTIVE: begin
          r_state    <= w_next;
          r_pins_out <= w_cond ? w_word[F_OUTT_LSB +: F_OUT_W]
                               : w_word[F_OUTF_LSB +: F_OUT_W];
          if (w_next != r_state)
            r_count <= '0;
          else if (r_count != CNT_MAX)
            r_count <= r_count + 1'b1;
        end
        default: begin
          // frozen: hold state, count and output
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_count    = r_count;
  assign o_pins_out = r_pins_out;
  assign o_irq      = r_irq;

endmodule

// File: tb/tb_prism_state_engine.sv
module tb_prism_state_engine;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [511:0] cfg_bus;
  logic         cfg_busy;
  logic [7:0]   pins;
  logic         irq_clr;
  logic [7:0]   pins_out;
  logic [2:0]   state;
  logic [15:0]  count;
  logic         irq;

  logic [63:0]  words [8];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] cnt;
    logic [7:0]  po;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  prism_state_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable   (enable),
    .i_cfg_bus  (cfg_bus),
    .i_cfg_busy (cfg_busy),
    .i_pins     (pins),
    .i_irq_clr  (irq_clr),
    .o_pins_out (pins_out),
    .o_state    (state),
    .o_count    (count),
    .o_irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cfg_bus = '0;
    for (int i = 0; i < 8; i++) cfg_bus[i*64 +: 64] = words[i];
  end

  function automatic logic [63:0] mkword(
    input logic [2:0] nt, input logic [2:0] nf,
    input logic [2:0] sa, input logic ia,
    input logic [2:0] sb_, input logic ib,
    input logic [1:0] op, input logic [7:0] ot, input logic [7:0] of,
    input logic [15:0] cmp, input logic cen, input logic ien);
    logic [63:0] w;
    w = '0;
    w[2:0]   = nt;  w[5:3]   = nf;
    w[8:6]   = sa;  w[9]     = ia;
    w[12:10] = sb_; w[13]    = ib;
    w[15:14] = op;  w[23:16] = ot;
    w[31:24] = of;  w[47:32] = cmp;
    w[48]    = cen; w[49]    = ien;
    w[63:50] = 14'h2A5A;  // reserved noise, must be ignored
    return w;
  endfunction

  // push the expectation, advance one edge, then pop and compare
  task automatic step(input string tag, input logic [2:0] st, input logic [15:0] cnt,
                      input logic [7:0] po, input logic ir);
    exp_t e;
    exp_t g;
    e.tag = tag; e.st = st; e.cnt = cnt; e.po = po; e.irq = ir;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    checks++;
    assert (state === g.st) else begin
      failures++;
      $error("FAIL %s.state got=%0d exp=%0d", g.tag, state, g.st);
    end
    checks++;
    assert (count === g.cnt) else begin
      failures++;
      $error("FAIL %s.count got=%0d exp=%0d", g.tag, count, g.cnt);
    end
    checks++;
    assert (pins_out === g.po) else begin
      failures++;
      $error("FAIL %s.pins_out got=%h exp=%h", g.tag, pins_out, g.po);
    end
    checks++;
    assert (irq === g.irq) else begin
      failures++;
      $error("FAIL %s.irq got=%b exp=%b", g.tag, irq, g.irq);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_busy = 1'b0; pins = 8'h00; irq_clr = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = 64'h0;
    #1;
    step("rst_a", 3'd0, 16'd0, 8'h00, 1'b0);
    step("rst_b", 3'd0, 16'd0, 8'h00, 1'b0);

    // all-zero words: false path, self loop keeps counting
    rst_n = 1'b1; enable = 1'b1;
    step("zero1", 3'd0, 16'd1, 8'h00, 1'b0);
    step("zero2", 3'd0, 16'd2, 8'h00, 1'b0);
    enable = 1'b0;
    step("idle0", 3'd0, 16'd0, 8'h00, 1'b0);

    words[0] = mkword(3'd3, 3'd0, 3'd2, 1'b0, 3'd5, 1'b0, 2'b01, 8'hA5, 8'h3C, 16'd0, 1'b0, 1'b0);
    words[3] = mkword(3'd2, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 2'b00, 8'hEE, 8'h11, 16'd0, 1'b0, 1'b0);
    words[1] = mkword(3'd2, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 2'b11, 8'h22, 8'h11, 16'd4, 1'b1, 1'b0);
    words[2] = mkword(3'd4, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 2'b11, 8'h44, 8'h0F, 16'd0, 1'b0, 1'b1);
    words[4] = mkword(3'd5, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0, 2'b11, 8'h55, 8'h0F, 16'd0, 1'b0, 1'b1);
    words[5] = mkword(3'd6, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 2'b11, 8'h66, 8'h5F, 16'd20, 1'b1, 1'b0);

    enable = 1'b1; pins = 8'h04;
    step("and_false", 3'd0, 16'd1, 8'h3C, 1'b0);
    pins = 8'b0010_0100;
    step("and_true", 3'd3, 16'd0, 8'hA5, 1'b0);
    pins = 8'h00;
    step("s3_false", 3'd1, 16'd0, 8'h11, 1'b0);
    for (int i = 1; i <= 4; i++) step("dwell", 3'd1, 16'(i), 8'h11, 1'b0);
    step("dwell_exit", 3'd2, 16'd0, 8'h22, 1'b0);
    step("irq_set", 3'd4, 16'd0, 8'h44, 1'b1);
    irq_clr = 1'b1;
    step("set_vs_clr", 3'd5, 16'd0, 8'h55, 1'b1);
    step("clr_alone", 3'd5, 16'd1, 8'h5F, 1'b0);
    irq_clr = 1'b0;
    step("dwell5", 3'd5, 16'd2, 8'h5F, 1'b0);

    // freeze; a word rewritten now applies on the first active cycle
    cfg_busy = 1'b1;
    words[5] = mkword(3'd5, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 2'b11, 8'h66, 8'h5F, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("frozen", 3'd5, 16'd2, 8'h5F, 1'b0);
    cfg_busy = 1'b0;
    step("resume1", 3'd5, 16'd3, 8'h66, 1'b1);
    step("resume2", 3'd5, 16'd4, 8'h66, 1'b1);

    enable = 1'b0;
    step("en_drop", 3'd0, 16'd0, 8'h00, 1'b1);
    rst_n = 1'b0;
    step("rst_mid", 3'd0, 16'd0, 8'h00, 1'b0);

    // cmp = 0 with cnt_en exits after a single cycle
    rst_n = 1'b1;
    words[0] = mkword(3'd6, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 2'b11, 8'h60, 8'h00, 16'd0, 1'b1, 1'b0);
    words[6] = mkword(3'd0, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 2'b11, 8'h61, 8'h06, 16'd0, 1'b1, 1'b0);
    enable = 1'b1;
    step("cmp0_in", 3'd6, 16'd0, 8'h60, 1'b0);
    step("cmp0_out", 3'd0, 16'd0, 8'h61, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
